// File: rtl/transit_timer_if.sv
// Sensor inputs, result handshake and status outputs of transit_timer_scheduler.
// The scheduler takes the slave side; the sensor front end and consumer take the master side.
interface transit_timer_if;
   logic [3:0]  entry_in;
   logic [3:0]  exit_in;
   logic        res_ready;
   logic        res_valid;
   logic [1:0]  res_sec;
   logic [18:0] res_ms;
   logic        res_timeout;
   logic [3:0]  busy;
   logic        ms_tick;

   modport master (
      output entry_in, exit_in, res_ready,
      input  res_valid, res_sec, res_ms, res_timeout, busy, ms_tick
   );

   modport slave (
      input  entry_in, exit_in, res_ready,
      output res_valid, res_sec, res_ms, res_timeout, busy, ms_tick
   );
endinterface

// File: rtl/transit_timer_scheduler.sv
// Per-section train transit timing sharing one ms prescaler and timestamp, with
// round-robin arbitration of completed results onto a single valid/ready port.
module transit_timer_scheduler #(
   parameter int CLK_PER_MS = 50000,
   parameter int N_SEC      = 4,
   parameter int TIMEOUT_MS = 60000
) (
   input  logic           clk,
   input  logic           rst,
   transit_timer_if.slave bus
);
   localparam int              PW        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_PER_MS - 1);
   localparam logic [18:0]     TIMEOUT   = 19'(TIMEOUT_MS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sec_state_t;

   logic [PW-1:0]    presc;
   logic [18:0]      timestamp;
   logic             tick;

   logic [N_SEC-1:0] prev_entry;
   logic [N_SEC-1:0] prev_exit;
   logic [N_SEC-1:0] entry_edge;
   logic [N_SEC-1:0] exit_edge;

   sec_state_t       state_q [N_SEC];
   sec_state_t       state_d [N_SEC];
   logic [18:0]      start_q [N_SEC];
   logic [18:0]      start_d [N_SEC];
   logic [18:0]      rslt_q  [N_SEC];
   logic [18:0]      rslt_d  [N_SEC];
   logic             tout_q  [N_SEC];
   logic             tout_d  [N_SEC];
   logic [18:0]      elapsed [N_SEC];

   logic [1:0]       rr_ptr;
   logic [1:0]       cand;
   logic [1:0]       grant_idx;
   logic             grant_found;
   logic             load;

   logic             res_valid_q;
   logic [1:0]       res_sec_q;
   logic [18:0]      res_ms_q;
   logic             res_to_q;

   assign tick       = (presc == PRESC_MAX);
   assign entry_edge = bus.entry_in & ~prev_entry;
   assign exit_edge  = bus.exit_in & ~prev_exit;
   assign load       = !res_valid_q || bus.res_ready;

   // NOTE: every signal written in an always_comb gets a default at the top of the
   // block, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = 2'd0;
      cand        = 2'd0;
      for (int k = 0; k < N_SEC; k++) begin
         cand = rr_ptr + 2'(k);
         if (!grant_found && state_q[cand] == S_DONE) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Section FSMs; a section leaves DONE only on the edge its result is loaded.
   always_comb begin
      for (int i = 0; i < N_SEC; i++) begin
         state_d[i] = state_q[i];
         start_d[i] = start_q[i];
         rslt_d[i]  = rslt_q[i];
         tout_d[i]  = tout_q[i];
         elapsed[i] = timestamp - start_q[i];
         case (state_q[i])
            S_IDLE: begin
               if (entry_edge[i]) begin
                  state_d[i] = S_RUN;
                  start_d[i] = timestamp;
               end
            end
            S_RUN: begin
               if (exit_edge[i]) begin
                  state_d[i] = S_DONE;
                  rslt_d[i]  = elapsed[i];
                  tout_d[i]  = 1'b0;
               end else if (elapsed[i] >= TIMEOUT) begin
                  state_d[i] = S_DONE;
                  rslt_d[i]  = TIMEOUT;
                  tout_d[i]  = 1'b1;
               end
            end
            S_DONE: begin
               if (load && grant_found && grant_idx == 2'(i)) state_d[i] = S_IDLE;
            end
            default: state_d[i] = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc       <= '0;
         timestamp   <= '0;
         prev_entry  <= '0;
         prev_exit   <= '0;
         rr_ptr      <= 2'd0;
         res_valid_q <= 1'b0;
         res_sec_q   <= 2'd0;
         res_ms_q    <= '0;
         res_to_q    <= 1'b0;
         // NOTE: the per-section arrays are small flop banks, not RAM, so clearing
         // them in reset is cheap and keeps stale results from leaking out.
         for (int i = 0; i < N_SEC; i++) begin
            state_q[i] <= S_IDLE;
            start_q[i] <= '0;
            rslt_q[i]  <= '0;
            tout_q[i]  <= 1'b0;
         end
      end else begin
         presc      <= tick ? '0 : presc + 1'b1;
         timestamp  <= timestamp + 19'(tick);
         prev_entry <= bus.entry_in;
         prev_exit  <= bus.exit_in;
         for (int i = 0; i < N_SEC; i++) begin
            state_q[i] <= state_d[i];
            start_q[i] <= start_d[i];
            rslt_q[i]  <= rslt_d[i];
            tout_q[i]  <= tout_d[i];
         end
         if (load) begin
            res_valid_q <= grant_found;
            if (grant_found) begin
               res_sec_q <= grant_idx;
               res_ms_q  <= rslt_q[grant_idx];
               res_to_q  <= tout_q[grant_idx];
               rr_ptr    <= grant_idx + 2'd1;
            end
         end
      end
   end

   always_comb begin
      bus.busy = '0;
      for (int i = 0; i < N_SEC; i++) bus.busy[i] = (state_q[i] == S_RUN);
   end

   assign bus.ms_tick     = tick;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_sec     = res_sec_q;
   assign bus.res_ms      = res_ms_q;
   assign bus.res_timeout = res_to_q;
endmodule

// File: doc/transit_timer_scheduler.md
Name: transit_timer_scheduler

Overview:
Sequences train transit-time measurement across several track sections. It shares one millisecond prescaler and one free-running ms timestamp counter between all sections. Each section has an entry/exit sensor pair: the entry edge starts timing and the exit edge stops it. Completed results, including timeouts, go through a round-robin arbiter onto a single valid/ready result port read by the speed/safety logic.

Parameters:
CLK_PER_MS, 50000, clk cycles per millisecond tick (>=2)
N_SEC, 4, number of track sections (fixed 4; res_sec is 2 bits)
TIMEOUT_MS, 60000, max transit time before forced timeout result (< 2^19)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
entry_in  in  4  entry sensor per section, synchronous level
exit_in  in  4  exit sensor per section, synchronous level
res_ready  in  1  consumer accepts result
res_valid  out  1  result available
res_sec  out  2  section index of result
res_ms  out  19  elapsed time in ms
res_timeout  out  1  result produced by timeout, not exit
busy  out  4  section is timing (RUN state)
ms_tick  out  1  one-cycle pulse per elapsed ms

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs, prescaler, timestamp, start stamps, edge-detect history and RR pointer go to 0.
  - All sections go to IDLE.
  - Applies mid-measurement: any in-flight timing and any pending or presented result is discarded.
- Prescaler: counts 0..CLK_PER_MS-1. ms_tick=1 during the cycle it equals CLK_PER_MS-1, then it wraps to 0.
- Timestamp: 19-bit, increments on ms_tick, wraps mod 2^19.
- Edge detect: prev_entry/prev_exit are registered each cycle. An edge is in=1 with prev=0, evaluated at the same posedge.
- Per-section FSM, states IDLE, RUN, DONE:
  - IDLE: entry edge -> RUN; start stamp <= current timestamp (pre-increment value if ms_tick is in the same cycle). Exit edge is ignored.
  - RUN: elapsed = (timestamp - start) mod 2^19.
    - Exit edge -> DONE; result = elapsed, timeout flag = 0.
    - Otherwise, if elapsed >= TIMEOUT_MS -> DONE; result = TIMEOUT_MS, flag = 1.
    - Entry edges are ignored.
  - DONE: holds result and flag until granted to the output register, then -> IDLE. All sensor edges are ignored in DONE.
- Simultaneous edges:
  - IDLE with entry+exit edges in the same cycle: entry wins -> RUN.
  - RUN with exit edge and timeout in the same cycle: exit wins (flag=0).
- busy[i] = 1 iff section i is in RUN.
- Output register / arbiter:
  - Loads when res_valid=0, or res_valid&&res_ready (accept and reload in the same cycle allowed, no bubble).
  - Grants the first DONE section scanning from rr_ptr upward mod 4; rr_ptr <= granted+1.
  - The granted section goes to IDLE on that edge.
  - res_valid stays high and res_sec/res_ms/res_timeout stay stable until accepted.
- Latency: exit edge sampled at posedge k -> DONE after k. Earliest res_valid=1 after posedge k+1.
- Resolution: whole ms ticks between start and stop, so true time is within ±1 ms. Sensor debounce is the caller's responsibility.

Test Plan:
- Bench uses CLK_PER_MS=10, TIMEOUT_MS=100.
1. Reset then idle 50 cycles -> res_valid=0, busy=0000, ms_tick every 10th cycle, timestamp=5.
2. Section 0: entry at ms 3, exit at ms 28, res_ready=1 -> single result res_sec=0, res_ms=25, res_timeout=0; res_valid is high exactly 1 cycle, 2 cycles after the exit edge.
3. Section 2: entry, no exit -> after 100 ms res_sec=2, res_ms=100, res_timeout=1; busy[2] falls.
4. Sections 1 and 3 exit in the same cycle with res_ready=0 for 20 cycles, then 1 -> section 1 is presented first (rr_ptr=0), held stable; section 3 is presented the cycle after acceptance.
5. Preload timestamp near wrap (run 524280 ms or force), entry at 524285, exit at 524293 (post-wrap value 5) -> res_ms=8.
6. Section 0 in RUN, assert rst for 1 cycle mid-measurement, then exit edge -> no result, busy=0000; entry+exit edges in the same IDLE cycle -> busy[0]=1.
